keypad_matrix_scan: RTL and testbench
=====================================

# keypad_matrix_scan

Upstream front end for the alarm-clock keypad entry path. Drives the columns of a 4x4 active-low key matrix, samples the rows, debounces a press, and presents the encoded key position on `key_row`/`key_col` with a `keypad_int` strobe. The four-digit entry buffer consumes these signals and shifts each decoded digit in on the rising edge of `keypad_int`. Exactly one event is emitted per debounced press; release is debounced too.

## Interface
- `SCAN_DWELL`, 4: cycles each column is driven before its rows are evaluated (min 3)
- `DEBOUNCE_CYCLES`, 8: consecutive stable samples required to accept a press or a release (min 2)
- `REPEAT_CYCLES`, 64: auto-repeat interval; used only with `KEYPAD_REPEAT_EN`
- `clk`  in  1  system clock; one clock domain
- `rst`  in  1  reset, synchronous and active-high
- `row_in`  in  4  matrix rows, active-low (pulled up), asynchronous
- `col_out`  out  4  column drive, active-low one-hot
- `key_row`  out  2  row index of accepted key
- `key_col`  out  2  column index of accepted key
- `keypad_int`  out  1  key event strobe, 2 cycles wide
- `key_valid`  out  1  high while an accepted key is held

## Operation
- `row_in` passes through a 2-flop synchronizer giving `row_sync`; all decisions use `row_sync` only.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN: column counter `c` (0..3) drives `col_out = ~(1<<c)`. Dwell counter runs 0..SCAN_DWELL-1. At the last dwell count: if `row_sync == 4'hF`, advance `c` (3 wraps to 0) and clear dwell; otherwise capture `pat = row_sync` and go to DEBOUNCE with `c` frozen.
- DEBOUNCE: each cycle compare `row_sync` to `pat`. A mismatch returns to SCAN, advancing `c`. A match increments the counter; on the DEBOUNCE_CYCLES-th consecutive match, accept and go to HELD.
- On accept: `key_row` = index of the lowest zero bit of `pat` (multi-row press: lowest row wins), `key_col = c`, and `key_valid` is set.
- HELD: column stays frozen. `row_sync == 4'hF` enters RELEASE with the counter cleared.
- RELEASE: DEBOUNCE_CYCLES consecutive all-ones samples clear `key_valid`, advance `c`, and enter SCAN. Any zero sample returns to HELD with no new event.
- Reset values: `col_out = 4'b1110`, `key_row = 0`, `key_col = 0`, `keypad_int = 0`, `key_valid = 0`, state SCAN, all counters 0.
- A reset asserted mid-operation behaves identically: the next edge restores all reset values and drops any in-progress strobe.

## Timing
- Acceptance edge: `key_row`, `key_col` and `key_valid` update.
- `keypad_int` is high on the two cycles after the acceptance edge, so the digit is stable one full cycle before the strobe's rising edge. It is never asserted without a preceding accept.
- `key_row`/`key_col` hold until the next accept; they do not change on release.
- Minimum press-to-strobe latency from a `row_in` change aligned to the evaluated column: 2 (sync) + up to SCAN_DWELL + DEBOUNCE_CYCLES + 1 cycles.
- Full scan period with no key pressed: 4*SCAN_DWELL cycles.
- Simultaneous release and accept is not possible: accept only occurs from DEBOUNCE, and release only from HELD.

## Configuration
- `KEYPAD_REPEAT_EN` defined: in HELD, a counter runs and re-issues a 2-cycle `keypad_int` every REPEAT_CYCLES cycles after the first strobe's rising edge. `key_row`/`key_col` are unchanged. The counter clears on leaving HELD.
- Without the macro: exactly one strobe per press, and REPEAT_CYCLES is ignored.

## Test plan
Bench defaults: SCAN_DWELL=4, DEBOUNCE_CYCLES=8.
- Reset held 3 cycles -> `col_out = 4'b1110`, all other outputs 0. Idle for 16 cycles -> columns cycle 1110, 1101, 1011, 0111 and back to 1110.
- Row 2 pulled low only while column 1 is driven, held 40 cycles -> `key_row = 2`, `key_col = 1`, `keypad_int` high exactly 2 cycles, `key_valid` high until 8 cycles after release plus sync.
- Bounce: row 0 toggles every 3 cycles for 30 cycles, then settles high -> no `keypad_int`, `key_valid` stays 0.
- Rows 1 and 3 low together on column 3 -> `key_row = 1`, `key_col = 3`, one strobe.
- Release glitch: in HELD, rows go high for 4 cycles then low again -> no second strobe, `key_valid` remains 1.
- `rst` asserted during the first `keypad_int` cycle -> `keypad_int = 0` on the next edge and all outputs at reset values; with `KEYPAD_REPEAT_EN` defined, a key held 200 cycles with REPEAT_CYCLES=64 gives strobes at offsets 0, 64 and 128.

Source files
------------

// File: rtl/keypad_matrix_scan.sv
// ============================================================================
// keypad_matrix_scan : 4x4 active-low key matrix scanner with press/release
// debounce and a 2-cycle key event strobe. Optional macro: KEYPAD_REPEAT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module keypad_matrix_scan #(
  parameter int SCAN_DWELL      = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [1:0] key_row,
  output logic [1:0] key_col,
  output logic       keypad_int,
  output logic       key_valid
);

  localparam int DW = $clog2(SCAN_DWELL);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [3:0]      row_meta;
  logic [3:0]      row_sync;
  logic [1:0]      col;
  logic [1:0]      col_n;
  logic [DW-1:0]   dwell;
  logic [DW-1:0]   dwell_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;
  logic [3:0]      pat;
  logic [3:0]      pat_n;
  logic            accept;
  logic            release_done;
  logic            fire;
  logic            int_pend;
  logic            int_hold;

  // Multi-row press: the lowest pulled-down row is reported.
  function automatic logic [1:0] lowest_zero(input logic [3:0] p);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!p[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  assign col_out = ~(4'b0001 << col);

  always_ff @(posedge clk) begin
    if (rst) state <= SCAN;
    else     state <= state_n;
  end

  always_comb begin
    state_n      = state;
    col_n        = col;
    dwell_n      = dwell;
    cnt_n        = cnt;
    pat_n        = pat;
    accept       = 1'b0;
    release_done = 1'b0;
    case (state)
      SCAN: begin
        if (dwell == DW'(SCAN_DWELL - 1)) begin
          dwell_n = '0;
          if (row_sync == 4'hF) begin
            col_n = col + 2'd1;
          end else begin
            pat_n   = row_sync;
            cnt_n   = '0;
            state_n = DEBOUNCE;
          end
        end else begin
          dwell_n = dwell + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (row_sync != pat) begin
          state_n = SCAN;
          col_n   = col + 2'd1;
          dwell_n = '0;
          cnt_n   = '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          accept  = 1'b1;
          state_n = HELD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HELD: begin
        if (row_sync == 4'hF) begin
          state_n = RELEASE;
          cnt_n   = '0;
        end
      end
      RELEASE: begin
        if (row_sync != 4'hF) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          release_done = 1'b1;
          state_n      = SCAN;
          col_n        = col + 2'd1;
          dwell_n      = '0;
          cnt_n        = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = SCAN;
    endcase
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);

  logic [RW-1:0] rep;
  logic          rep_fire;

  // Counter is zero on entry to HELD, so the first repeat lands exactly
  // REPEAT_CYCLES after the first strobe's rising edge.
  assign rep_fire = (state == HELD) && (rep == RW'(REPEAT_CYCLES - 1));
  assign fire     = accept | rep_fire;

  always_ff @(posedge clk) begin
    if (rst || state != HELD) rep <= '0;
    else if (rep_fire)        rep <= '0;
    else                      rep <= rep + 1'b1;
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^REPEAT_CYCLES;
  assign fire              = accept;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta   <= 4'hF;
      row_sync   <= 4'hF;
      col        <= 2'd0;
      dwell      <= '0;
      cnt        <= '0;
      pat        <= 4'hF;
      key_row    <= 2'd0;
      key_col    <= 2'd0;
      key_valid  <= 1'b0;
      int_pend   <= 1'b0;
      int_hold   <= 1'b0;
      keypad_int <= 1'b0;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
      col      <= col_n;
      dwell    <= dwell_n;
      cnt      <= cnt_n;
      pat      <= pat_n;
      if (accept) begin
        key_row   <= lowest_zero(pat);
        key_col   <= col;
        key_valid <= 1'b1;
      end else if (release_done) begin
        key_valid <= 1'b0;
      end
      // Strobe trails the key code by one cycle so the digit is already stable.
      int_pend   <= fire;
      int_hold   <= int_pend;
      keypad_int <= int_pend | int_hold;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_keypad_matrix_scan.sv
// ============================================================================
// tb_keypad_matrix_scan : directed bench driving a modelled 4x4 key matrix.
// ============================================================================
`default_nettype none

module tb_keypad_matrix_scan;

  logic            clk;
  logic            rst;
  logic [3:0]      row_in;
  logic [3:0]      col_out;
  logic [1:0]      key_row;
  logic [1:0]      key_col;
  logic            keypad_int;
  logic            key_valid;
  logic [3:0][3:0] keys;   // keys[row][col] = 1 when that switch is closed

  int compared   = 0;
  int mismatched = 0;
  int tick_n     = 0;
  int press_t    = 0;
  logic prev_int = 1'b0;
  logic valid_seen;
  int rise_q[$];

  keypad_matrix_scan #(
    .SCAN_DWELL      (4),
    .DEBOUNCE_CYCLES (8),
    .REPEAT_CYCLES   (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_in     (row_in),
    .col_out    (col_out),
    .key_row    (key_row),
    .key_col    (key_col),
    .keypad_int (keypad_int),
    .key_valid  (key_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A closed switch pulls its row low while its column is driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[r] & ~col_out);
  end

  task automatic tick();
    @(negedge clk);
    tick_n++;
    if (keypad_int && !prev_int) rise_q.push_back(tick_n);
    prev_int = keypad_int;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input logic lvl, input int max, input string tag);
    for (int i = 0; i < max && key_valid !== lvl; i++) tick();
    chk(tag, 32'(key_valid), 32'(lvl));
  endtask

  initial begin
    rst  = 1'b1;
    keys = '0;
    repeat (3) tick();
    chk("rst_col_out", 32'(col_out), 32'hE);
    chk("rst_key_row", 32'(key_row), 0);
    chk("rst_key_col", 32'(key_col), 0);
    chk("rst_int", 32'(keypad_int), 0);
    chk("rst_valid", 32'(key_valid), 0);
    rst = 1'b0;

    repeat (4) tick();
    chk("scan_col1", 32'(col_out), 32'hD);
    repeat (4) tick();
    chk("scan_col2", 32'(col_out), 32'hB);
    repeat (4) tick();
    chk("scan_col3", 32'(col_out), 32'h7);
    repeat (4) tick();
    chk("scan_wrap", 32'(col_out), 32'hE);

    // Single press: row 2 / column 1
    rise_q.delete();
    press_t = tick_n;
    keys[2][1] = 1'b1;
    wait_valid(1'b1, 60, "press_valid");
    chk("press_key_row", 32'(key_row), 2);
    chk("press_key_col", 32'(key_col), 1);
    chk("press_int_lead", 32'(keypad_int), 0);
    tick();
    chk("press_int_c1", 32'(keypad_int), 1);
    tick();
    chk("press_int_c2", 32'(keypad_int), 1);
    tick();
    chk("press_int_c3", 32'(keypad_int), 0);
    while (tick_n < press_t + 40) tick();
    keys = '0;
    repeat (10) tick();
    chk("release_valid_hold", 32'(key_valid), 1);
    tick();
    chk("release_valid_clr", 32'(key_valid), 0);
    chk("release_col_adv", 32'(col_out), 32'hB);
    chk("release_key_row", 32'(key_row), 2);
    chk("release_key_col", 32'(key_col), 1);
    chk("press_one_strobe", 32'(rise_q.size()), 1);

    // Bounce on row 0 / column 0
    rise_q.delete();
    valid_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) keys[0][0] = ~keys[0][0];
      tick();
      valid_seen |= key_valid;
    end
    keys = '0;
    repeat (12) begin
      tick();
      valid_seen |= key_valid;
    end
    chk("bounce_no_strobe", 32'(rise_q.size()), 0);
    chk("bounce_no_valid", 32'(valid_seen), 0);

    // Two rows on column 3, then a short release glitch
    rise_q.delete();
    keys[1][3] = 1'b1;
    keys[3][3] = 1'b1;
    wait_valid(1'b1, 60, "multi_valid");
    chk("multi_key_row", 32'(key_row), 1);
    chk("multi_key_col", 32'(key_col), 3);
    repeat (10) tick();
    chk("multi_one_strobe", 32'(rise_q.size()), 1);
    keys = '0;
    repeat (4) tick();
    keys[1][3] = 1'b1;
    keys[3][3] = 1'b1;
    repeat (20) tick();
    chk("glitch_valid", 32'(key_valid), 1);
    chk("glitch_no_strobe", 32'(rise_q.size()), 1);
    keys = '0;
    wait_valid(1'b0, 40, "multi_release");

    // Reset during the first strobe cycle
    keys[3][2] = 1'b1;
    wait_valid(1'b1, 60, "rstint_valid");
    tick();
    chk("rstint_int_high", 32'(keypad_int), 1);
    rst  = 1'b1;
    keys = '0;
    tick();
    chk("rstint_int", 32'(keypad_int), 0);
    chk("rstint_valid", 32'(key_valid), 0);
    chk("rstint_key_row", 32'(key_row), 0);
    chk("rstint_key_col", 32'(key_col), 0);
    chk("rstint_col_out", 32'(col_out), 32'hE);
    rst = 1'b0;
    repeat (2) tick();

    // Long hold: 200 cycles from press
    rise_q.delete();
    press_t = tick_n;
    keys[0][1] = 1'b1;
    wait_valid(1'b1, 60, "hold_valid");
    while (tick_n < press_t + 200) tick();
`ifdef KEYPAD_REPEAT_EN
    chk("repeat_count", 32'(rise_q.size()), 3);
    if (rise_q.size() >= 3) begin
      chk("repeat_off1", 32'(rise_q[1] - rise_q[0]), 64);
      chk("repeat_off2", 32'(rise_q[2] - rise_q[0]), 128);
    end
`else
    chk("hold_single_strobe", 32'(rise_q.size()), 1);
`endif
    chk("hold_key_row", 32'(key_row), 0);
    chk("hold_key_col", 32'(key_col), 1);
    keys = '0;
    wait_valid(1'b0, 40, "hold_release");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
